// File: rtl/sfp_writeback.sv
// SFP writeback stage: requantizes each row of signed partial sums to bw-bit activations and writes
// them to the activation SRAM through a 2-entry buffer. Optional ReLU clamp: define SFP_WB_RELU_EN.
module sfp_writeback #(
    parameter int col     = 8,
    parameter int bw      = 8,
    parameter int bw_psum = 2*bw+4,
    parameter int addr_w  = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [addr_w-1:0]        base_addr,
    input  logic [addr_w-1:0]        num_rows,
    input  logic [3:0]               shift,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [col*bw_psum-1:0]   sfp_in,
    output logic                     mem_wr,
    input  logic                     mem_ready,
    output logic [addr_w-1:0]        mem_addr,
    output logic [col*bw-1:0]        mem_data,
    output logic                     busy,
    output logic                     done,
    output logic                     drop_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [addr_w-1:0]         ONE_ADDR = {{(addr_w-1){1'b0}}, 1'b1};
    localparam logic signed [bw_psum:0]   ONE_EXT  = {{bw_psum{1'b0}}, 1'b1};
    localparam logic signed [bw_psum:0]   SAT_MAX  = {{(bw_psum+2-bw){1'b0}}, {(bw-1){1'b1}}};
    localparam logic signed [bw_psum:0]   SAT_MIN  = {{(bw_psum+2-bw){1'b1}}, {(bw-1){1'b0}}};

    logic [1:0]              state;
    logic [addr_w-1:0]       cfg_rows;
    logic [3:0]              cfg_shift;
    logic [addr_w-1:0]       wr_addr;
    logic [addr_w-1:0]       in_cnt;
    logic [addr_w-1:0]       out_cnt;

    logic                    out_valid;
    logic [col*bw-1:0]       out_data;
    logic [addr_w-1:0]       out_addr;
    logic                    skid_valid;
    logic [col*bw-1:0]       skid_data;
    logic [addr_w-1:0]       skid_addr;

    logic [col*bw-1:0]       row_q;
    logic                    accept;
    logic                    drain;
    logic                    last_beat;

    // One extra bit of headroom keeps the rounding add from overflowing before the shift.
    function automatic logic [bw-1:0] requant(input logic signed [bw_psum-1:0] lane,
                                              input logic [3:0] sh);
        logic signed [bw_psum:0] ext;
        logic signed [bw_psum:0] half;
        logic signed [bw_psum:0] rounded;
        logic signed [bw_psum:0] shifted;
        logic [bw-1:0]           result;
        ext = {lane[bw_psum-1], lane};
`ifdef SFP_WB_RELU_EN
        if (ext[bw_psum]) begin
            ext = '0;
        end
`endif
        half = '0;
        if (sh != 4'd0) begin
            half = ONE_EXT << (sh - 4'd1);
        end
        rounded = ext + half;
        shifted = rounded >>> sh;
        if (shifted > SAT_MAX) begin
            result = SAT_MAX[bw-1:0];
        end else if (shifted < SAT_MIN) begin
            result = SAT_MIN[bw-1:0];
        end else begin
            result = shifted[bw-1:0];
        end
        return result;
    endfunction

    genvar k;
    generate
        for (k = 0; k < col; k++) begin : g_lane
            assign row_q[bw*k +: bw] = requant(sfp_in[bw_psum*k +: bw_psum], cfg_shift);
        end
    endgenerate

    assign in_ready  = (state == RUN) && !skid_valid && (in_cnt < cfg_rows);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && mem_ready;
    assign last_beat = drain && (out_cnt == (cfg_rows - ONE_ADDR));

    assign mem_wr   = out_valid;
    assign mem_addr = out_addr;
    assign mem_data = out_data;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    // Frame control; a zero row count still produces one row so the frame always terminates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cfg_rows  <= '0;
            cfg_shift <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        cfg_rows  <= (num_rows == '0) ? ONE_ADDR : num_rows;
                        cfg_shift <= shift;
                    end
                end
                RUN: begin
                    if (last_beat) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Addresses are bound at accept time, which preserves write order through the buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_addr <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else if ((state == IDLE) && start) begin
            wr_addr <= base_addr;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            if (accept) begin
                wr_addr <= wr_addr + ONE_ADDR;
                in_cnt  <= in_cnt + ONE_ADDR;
            end
            if (drain) begin
                out_cnt <= out_cnt + ONE_ADDR;
            end
        end
    end

    // Output register refills from the skid first so rows never reorder.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_addr   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_addr  <= '0;
        end else if (drain || !out_valid) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                out_addr   <= skid_addr;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                out_data  <= row_q;
                out_addr  <= wr_addr;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_data  <= row_q;
            skid_addr  <= wr_addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_err <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                drop_err <= 1'b0;
            end else if (in_valid) begin
                drop_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/sfp_writeback.md
Name: sfp_writeback

Overview:
- Downstream stage of the SFP row. Takes each normalized row of col signed bw_psum-bit lanes from the SFP divide output.
- Requantizes every lane to a signed bw-bit activation using a programmable right shift, round-half-up and saturation.
- Packs the col lanes into one col*bw-bit word and writes it to the activation SRAM at an auto-incrementing address.
- A 2-entry output buffer with ready/valid backpressure sits in front of the SRAM port; a small FSM counts rows per frame and signals completion.

Parameters:
- col, 8, lanes per row
- bw, 8, output activation width (signed)
- bw_psum, 2*bw+4, input lane width (signed)
- addr_w, 11, SRAM address width

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- start  input  1  one-cycle pulse; latches base_addr, num_rows, shift; IDLE only
- base_addr  input  addr_w  first write address of frame
- num_rows  input  addr_w  rows in frame; 0 treated as 1
- shift  input  4  arithmetic right-shift amount, 0..15
- in_valid  input  1  sfp_in carries a valid row (driven one cycle after div)
- in_ready  output  1  block can accept a row this cycle
- sfp_in  input  col*bw_psum  signed lanes, lane k at [bw_psum*(k+1)-1 : bw_psum*k]
- mem_wr  output  1  write request
- mem_ready  input  1  SRAM accepts the write this cycle
- mem_addr  output  addr_w  write address
- mem_data  output  col*bw  packed bytes, lane k at [bw*(k+1)-1 : bw*k]
- busy  output  1  FSM not in IDLE
- done  output  1  one-cycle pulse after the last row is accepted by the SRAM
- drop_err  output  1  sticky; in_valid seen while IDLE; cleared by start

Behaviour:
- Reset: FSM=IDLE; in_ready=0; mem_wr=0; mem_addr=0; mem_data=0; busy=0; done=0; drop_err=0; buffer empty; all counters 0.
- FSM IDLE:
  - start -> RUN; latch config; wr_addr=base_addr; in_cnt=0; out_cnt=0; drop_err=0.
  - in_valid in IDLE -> drop_err=1; data discarded.
- FSM RUN:
  - in_ready = (skid entry empty) AND (in_cnt < num_rows).
  - Accept when in_valid & in_ready; in_cnt++.
  - When out_cnt reaches num_rows (last mem_wr & mem_ready) -> DONE.
- FSM DONE: done=1 for exactly one cycle -> IDLE.
- start outside IDLE is ignored.
- Per-lane math, combinational on the input:
  - Sign-extend the lane to bw_psum+1 bits.
  - If shift>0, add 1<<(shift-1) (round half up toward +inf).
  - Arithmetic shift right by shift.
  - Saturate to [-2^(bw-1), 2^(bw-1)-1].
- Buffer: output register plus one skid register.
  - An accepted row enters the output register if it is empty or draining this cycle; otherwise it enters the skid.
  - Skid moves to the output register when the output register drains.
- Latency: row accepted in cycle N with the buffer empty -> mem_wr=1 with its data in cycle N+1.
- Output hold: mem_wr, mem_addr and mem_data hold stable while mem_ready=0.
- Address: each beat takes wr_addr, then wr_addr increments; wraps modulo 2^addr_w with no error.
- Simultaneous accept and drain with the skid full is impossible (in_ready=0); accept and drain with the skid empty is throughput 1 row/cycle.
- Reset mid-frame: immediately returns to the reset state; buffered rows are lost.

Optional Feature:
- SFP_WB_RELU_EN defined: a negative lane is forced to 0 before rounding, so outputs are in [0, 2^(bw-1)-1].
- Undefined: signed requantization exactly as in Behaviour.

Test Plan:
- base_addr=0x010, num_rows=1, shift=4, lanes {56, -24, 0, 7, 8, -8, 15, 16}, mem_ready=1 -> one beat at cycle N+1, addr 0x010, bytes {04, FF, 00, 00, 01, 00, 01, 01}; done pulse; busy falls.
- Saturation, shift=4, lanes {5000, -5000, 2047, -2049, ...} -> {7F, 80, 7F, 80}; with SFP_WB_RELU_EN -> {7F, 00, 7F, 00}.
- num_rows=4, in_valid every cycle, mem_ready low for 3 cycles after the first beat:
  - in_ready drops after the skid fills;
  - mem_* stable while stalled;
  - addresses 0x010..0x013 written in order with no loss or duplicates;
  - exactly one done.
- base_addr=0x7FE (addr_w=11), num_rows=3 -> writes at 0x7FE, 0x7FF, 0x000.
- in_valid pulsed in IDLE -> no mem_wr; drop_err=1; next start clears it.
- Assert reset after 2 of 4 rows accepted -> all outputs 0 next cycle; a new start replays a full frame correctly.
